// File: rtl/ram_row_reader.sv
// Reads num_rows strided rows from a 1-cycle-latency RAM and streams them out,
// lane-masked, through a 2-entry FIFO with valid/ready handshake.
module ram_row_reader #(
  parameter int DWIDTH            = 8,
  parameter int DESIGN_SIZE       = 32,
  parameter int AWIDTH            = 10,
  parameter int ADDR_STRIDE_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [AWIDTH-1:0]             start_addr,
  input  logic [ADDR_STRIDE_WIDTH-1:0]  addr_stride,
  input  logic [5:0]                    num_rows,
  input  logic [DESIGN_SIZE-1:0]        valid_mask,
  output logic [AWIDTH-1:0]             ram_addr,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] ram_q,
  output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  localparam int WORDW = DESIGN_SIZE * DWIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic [AWIDTH-1:0]      r_ramAddr;
  logic [AWIDTH-1:0]      r_stride;
  logic [5:0]             r_numRows;
  logic [5:0]             r_issueCnt;
  logic [DESIGN_SIZE-1:0] r_validMask;

  logic [WORDW-1:0]       r_fifoData [2];
  logic                   r_fifoLast [2];
  logic                   r_wrPtr;
  logic                   r_rdPtr;
  logic [1:0]             r_count;
  logic                   r_inFlight;
  logic                   r_inFlightLast;

  logic                   w_pop;
  logic                   w_issueOk;
  logic                   w_issue;
  logic                   w_issueLast;
  logic                   w_headLast;
  logic [WORDW-1:0]       w_laneMask;
  logic                   w_unusedStrideBits;

  // ram_addr always holds the next row to read; an "issue" is the edge where
  // the RAM samples it, so the row's data is captured exactly one edge later.
  assign w_pop       = out_valid && out_ready;
  assign w_issueOk   = ({1'b0, r_count} + {2'b00, r_inFlight}) < (3'd2 + {2'b00, w_pop});
  assign w_issue     = (r_state == FETCH) && w_issueOk;
  assign w_issueLast = (r_issueCnt == (r_numRows - 6'd1));
  assign w_headLast  = r_fifoLast[r_rdPtr];

  assign w_unusedStrideBits = ^addr_stride;

  assign ram_addr  = r_ramAddr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = out_valid ? r_fifoData[r_rdPtr] : '0;
  assign out_last  = out_valid && w_headLast;

  always_comb begin
    w_laneMask = '0;
    for (int i = 0; i < DESIGN_SIZE; i++) begin
      w_laneMask[i*DWIDTH +: DWIDTH] = {DWIDTH{r_validMask[i]}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ramAddr   <= '0;
      r_stride    <= '0;
      r_numRows   <= '0;
      r_issueCnt  <= '0;
      r_validMask <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ramAddr   <= start_addr;
            r_stride    <= addr_stride[AWIDTH-1:0];
            r_numRows   <= num_rows;
            r_validMask <= valid_mask;
            r_issueCnt  <= '0;
            r_busy      <= 1'b1;
            if (num_rows == 6'd0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= FETCH;
            end
          end
        end
        FETCH: begin
          // The last issue leaves ram_addr on the final row rather than stepping past it.
          if (w_issue) begin
            r_issueCnt <= r_issueCnt + 6'd1;
            if (w_issueLast) begin
              r_state <= DRAIN;
            end else begin
              r_ramAddr <= r_ramAddr + r_stride;
            end
          end
        end
        DRAIN: begin
          if (w_pop && w_headLast) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Masking at capture time is equivalent to masking the head: the mask is fixed per transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_fifoData[i] <= '0;
        r_fifoLast[i] <= 1'b0;
      end
      r_wrPtr        <= 1'b0;
      r_rdPtr        <= 1'b0;
      r_count        <= 2'd0;
      r_inFlight     <= 1'b0;
      r_inFlightLast <= 1'b0;
    end else begin
      r_inFlight     <= w_issue;
      r_inFlightLast <= w_issue && w_issueLast;
      if (r_inFlight) begin
        r_fifoData[r_wrPtr] <= ram_q & w_laneMask;
        r_fifoLast[r_wrPtr] <= r_inFlightLast;
        r_wrPtr             <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({r_inFlight, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_row_reader.sv
// Directed bench for ram_row_reader: a vector table of whole transfers plus
// hand-written sequences for exact timing, zero-row starts and mid-transfer reset.
module tb_ram_row_reader;

  localparam int DW = 8;
  localparam int DS = 32;
  localparam int AW = 10;
  localparam int SW = 16;
  localparam int WW = DS * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [SW-1:0] addr_stride;
  logic [5:0]    num_rows;
  logic [DS-1:0] valid_mask;
  logic [AW-1:0] ram_addr;
  logic [WW-1:0] ram_q;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  int   checks   = 0;
  int   failures = 0;
  logic ramAllAA = 1'b0;

  typedef struct {
    logic [AW-1:0] startAddr;
    logic [SW-1:0] stride;
    logic [5:0]    numRows;
    logic [DS-1:0] mask;
    logic [3:0]    readyPat;
    logic          allAA;
    logic [AW-1:0] lastAddr;
  } vec_t;

  vec_t vecs [7];

  ram_row_reader #(
    .DWIDTH(DW), .DESIGN_SIZE(DS), .AWIDTH(AW), .ADDR_STRIDE_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .addr_stride(addr_stride), .num_rows(num_rows), .valid_mask(valid_mask),
    .ram_addr(ram_addr), .ram_q(ram_q), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Lanes 0 and 1 together encode the full address so every row is distinguishable.
  function automatic logic [WW-1:0] genWord(input logic [AW-1:0] a);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < DS; i++) begin
      if (i == 0)      w[7:0]        = a[7:0];
      else if (i == 1) w[15:8]       = {6'b0, a[9:8]};
      else             w[i*DW +: DW] = a[7:0] ^ 8'(i * 29);
    end
    return w;
  endfunction

  function automatic logic [WW-1:0] expandMask(input logic [DS-1:0] m);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < DS; i++) w[i*DW +: DW] = {DW{m[i]}};
    return w;
  endfunction

  always @(posedge clk) ram_q <= ramAllAA ? {DS{8'hAA}} : genWord(ram_addr);

  task automatic checkOutput(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] sa, input logic [SW-1:0] st,
                               input logic [5:0] nr, input logic [DS-1:0] m);
    start_addr  = sa;
    addr_stride = st;
    num_rows    = nr;
    valid_mask  = m;
    start       = 1'b1;
  endtask

  task automatic runVector(input vec_t v);
    logic [WW-1:0] heldData;
    logic [WW-1:0] expData;
    logic [AW-1:0] a;
    logic          heldLast;
    logic          stalled;
    logic          doneSeen;
    logic          rdy;
    int            k;
    ramAllAA  = v.allAA;
    out_ready = 1'b0;
    @(negedge clk);
    applyStimulus(v.startAddr, v.stride, v.numRows, v.mask);
    @(negedge clk);
    start    = 1'b0;
    k        = 0;
    stalled  = 1'b0;
    doneSeen = 1'b0;
    heldData = '0;
    heldLast = 1'b0;
    for (int cyc = 0; cyc < 400 && !doneSeen; cyc++) begin
      if (done) begin
        doneSeen = 1'b1;
        checkOutput("doneNoValid", {255'b0, out_valid}, '0);
      end else begin
        rdy = v.readyPat[cyc % 4];
        if (stalled) begin
          checkOutput("stallValid", {255'b0, out_valid}, {255'b0, 1'b1});
          checkOutput("stallData", out_data, heldData);
          checkOutput("stallLast", {255'b0, out_last}, {255'b0, heldLast});
        end
        stalled = 1'b0;
        if (out_valid) begin
          if (rdy) begin
            a = (k == int'(v.numRows) - 1) ? v.lastAddr : AW'(v.startAddr + AW'(k) * v.stride[AW-1:0]);
            expData = (v.allAA ? {DS{8'hAA}} : genWord(a)) & expandMask(v.mask);
            checkOutput("rowData", out_data, expData);
            checkOutput("rowLast", {255'b0, out_last}, {255'b0, (k == int'(v.numRows) - 1)});
            k++;
          end else begin
            stalled  = 1'b1;
            heldData = out_data;
            heldLast = out_last;
          end
        end
        out_ready = rdy;
        @(negedge clk);
      end
    end
    checkOutput("rowCount", WW'(k), WW'(v.numRows));
    checkOutput("doneSeen", {255'b0, doneSeen}, {255'b0, 1'b1});
    @(negedge clk);
    checkOutput("doneOneCycle", {255'b0, done}, '0);
    checkOutput("busyAfterDone", {255'b0, busy}, '0);
    out_ready = 1'b0;
  endtask

  logic [AW-1:0] seqAddr  [8] = '{10'h010, 10'h030, 10'h050, 10'h070, 10'h070, 10'h070, 10'h070, 10'h070};
  logic          seqValid [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
  logic          seqLast  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  logic          seqDone  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  logic          seqBusy  [8] = '{1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    int validCount;
    int rowsSeen;
    vecs[0] = '{10'h010, 16'd32,     6'd4,  32'hFFFF_FFFF, 4'b1111, 1'b0, 10'h070};
    vecs[1] = '{10'h3F0, 16'd32,     6'd2,  32'hFFFF_FFFF, 4'b1111, 1'b0, 10'h010};
    vecs[2] = '{10'h100, 16'd5,      6'd3,  32'hFFFF_FFFF, 4'b1001, 1'b0, 10'h10A};
    vecs[3] = '{10'h020, 16'd1,      6'd2,  32'h0000_FFFF, 4'b1111, 1'b1, 10'h021};
    vecs[4] = '{10'h200, 16'h0401,   6'd3,  32'h5555_5555, 4'b1010, 1'b0, 10'h202};
    vecs[5] = '{10'h000, 16'd3,      6'd32, 32'hF0F0_FFFF, 4'b1101, 1'b0, 10'h05D};
    vecs[6] = '{10'h3FF, 16'hFFFF,   6'd5,  32'hFFFF_FFFF, 4'b0110, 1'b0, 10'h3FB};

    reset       = 1'b1;
    start       = 1'b0;
    start_addr  = '0;
    addr_stride = '0;
    num_rows    = '0;
    valid_mask  = '0;
    out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstValid", {255'b0, out_valid}, '0);
    checkOutput("rstData", out_data, '0);
    checkOutput("rstLast", {255'b0, out_last}, '0);
    checkOutput("rstBusy", {255'b0, busy}, '0);
    checkOutput("rstDone", {255'b0, done}, '0);
    checkOutput("rstAddr", WW'(ram_addr), '0);
    reset = 1'b0;

    // Exact cycle timing with out_ready held high; a start pulse mid-transfer must be ignored.
    out_ready = 1'b1;
    @(negedge clk);
    applyStimulus(10'h010, 16'd32, 6'd4, 32'hFFFF_FFFF);
    rowsSeen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checkOutput($sformatf("seqAddr%0d", n), WW'(ram_addr), WW'(seqAddr[n]));
      checkOutput($sformatf("seqValid%0d", n), {255'b0, out_valid}, {255'b0, seqValid[n]});
      checkOutput($sformatf("seqLast%0d", n), {255'b0, out_last}, {255'b0, seqLast[n]});
      checkOutput($sformatf("seqDone%0d", n), {255'b0, done}, {255'b0, seqDone[n]});
      checkOutput($sformatf("seqBusy%0d", n), {255'b0, busy}, {255'b0, seqBusy[n]});
      if (seqValid[n]) begin
        checkOutput($sformatf("seqData%0d", n), out_data, genWord(AW'(10'h010 + AW'(rowsSeen) * 10'd32)));
        rowsSeen++;
      end
      start = (n == 3);
      if (n == 3) begin
        start_addr = 10'h200;
        num_rows   = 6'd0;
      end
    end
    start     = 1'b0;
    out_ready = 1'b0;

    // A zero-row start goes straight to DONE for a single cycle.
    @(negedge clk);
    applyStimulus(10'h055, 16'd7, 6'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    start = 1'b0;
    checkOutput("zeroBusy", {255'b0, busy}, {255'b0, 1'b1});
    checkOutput("zeroDone", {255'b0, done}, {255'b0, 1'b1});
    checkOutput("zeroValid", {255'b0, out_valid}, '0);
    @(negedge clk);
    checkOutput("zeroBusyEnd", {255'b0, busy}, '0);
    checkOutput("zeroDoneEnd", {255'b0, done}, '0);
    checkOutput("zeroValidEnd", {255'b0, out_valid}, '0);

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d", i);
      runVector(vecs[i]);
    end
    ramAllAA = 1'b0;

    // Reset right after the second row of an 8-row transfer discards everything pending.
    out_ready = 1'b1;
    @(negedge clk);
    applyStimulus(10'h080, 16'd4, 6'd8, 32'hFFFF_FFFF);
    @(negedge clk);
    start    = 1'b0;
    rowsSeen = 0;
    for (int cyc = 0; cyc < 20 && rowsSeen < 2; cyc++) begin
      if (out_valid) rowsSeen++;
      @(negedge clk);
    end
    checkOutput("midRowsBeforeReset", WW'(rowsSeen), WW'(2));
    reset = 1'b1;
    #1;
    checkOutput("midRstValid", {255'b0, out_valid}, '0);
    checkOutput("midRstData", out_data, '0);
    checkOutput("midRstLast", {255'b0, out_last}, '0);
    checkOutput("midRstBusy", {255'b0, busy}, '0);
    checkOutput("midRstDone", {255'b0, done}, '0);
    checkOutput("midRstAddr", WW'(ram_addr), '0);
    @(negedge clk);
    reset = 1'b0;
    validCount = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (out_valid || busy) validCount++;
    end
    checkOutput("noValidAfterReset", WW'(validCount), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
